// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline (fetch, hazard and decode units).
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
    logic               valid;
  } de_reg_t;

  // Instruction fetches are word-aligned; low address bits are simply discarded.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register: async reset to zero, synchronous clear beats load enable.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, PC+4 adder, stall counter and the IF/DE register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      de_instr,
  output logic [31:0]      de_pc4,
  output logic             de_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;
  de_reg_t           de_d;
  de_reg_t           de_q;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Redirect wins over stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = word_align(redirect_pc);
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Only cycles that actually freeze the pipe are counted; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !redirect && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    de_d       = '0;
    de_d.instr = imem_rdata;
    de_d.pc4   = pc_plus4;
    de_d.valid = 1'b1;
  end

  // Reset and flush both leave a zero word, which is exactly NOP with pc4=0 and valid=0.
  pipe_reg #(
    .W($bits(de_reg_t))
  ) u_de_reg (
    .clk  (clk),
    .rst  (rst),
    .load (!stall),
    .clear(redirect),
    .d    (de_d),
    .q    (de_q)
  );

  assign de_instr = de_q.instr;
  assign de_pc4   = de_q.pc4;
  assign de_valid = de_q.valid;

endmodule
